// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
// FSM state and transaction owner enums, plus width helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_e;

  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch (if_*), load/store (dm_*) and memory (mem_*) signals.
// master: arbiter side; slave: requesters plus memory side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = be_w(DATA_W);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner select between fetch and data, plus next starvation count.
// In: if_req, dm_req, starve_cnt. Out: pick_if, pick_dm, starve_nxt.
module mem_port_arbiter_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             pick_if,
  output logic             pick_dm,
  output logic [CNT_W-1:0] starve_nxt
);

  logic forced;

  always_comb begin
    forced     = if_req &&
                 (starve_cnt == CNT_W'(STARVE_LIMIT));
    pick_dm    = dm_req && !forced;
    pick_if    = if_req && !pick_dm;
    starve_nxt = starve_cnt;
    unique case (1'b1)
      pick_if: starve_nxt = '0;
      // dm only beats a waiting fetch below the limit,
      // so this increment saturates by construction
      pick_dm: if (if_req)
        starve_nxt = starve_cnt + CNT_W'(1);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// Ports: clk, rst_n (sync, active-low), bus (mem_port_arbiter_if.master).
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);
  import mem_port_arbiter_pkg::*;

  localparam int BE_W  = be_w(DATA_W);
  localparam int CNT_W = cnt_w(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_nxt;
  logic              pick_if;
  logic              pick_dm;
  logic              arb;
  logic              take;
  logic              rsp_raw;
  logic              rsp;

  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  mem_port_arbiter_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .if_req     (bus.if_req),
    .dm_req     (bus.dm_req),
    .starve_cnt (starve_q),
    .pick_if    (pick_if),
    .pick_dm    (pick_dm),
    .starve_nxt (starve_nxt)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    arb     = 1'b0;
    rsp_raw = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        arb = 1'b1;
        if (pick_dm) begin
          state_d = ARB_ISSUE;
          owner_d = OWN_DM;
        end else if (pick_if) begin
          state_d = ARB_ISSUE;
          owner_d = OWN_IF;
        end
      end
      ARB_ISSUE: begin
        if (bus.mem_gnt) begin
          rsp_raw = bus.mem_rvalid;
          state_d = bus.mem_rvalid ? ARB_IDLE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        rsp_raw = bus.mem_rvalid;
        if (bus.mem_rvalid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (state_d == ARB_IDLE) owner_d = OWN_NONE;
  end

  // Reset held low masks grants and responses, so an
  // aborted transaction never delivers data.
  assign take = arb && rst_n && (pick_if || pick_dm);
  assign rsp  = rsp_raw && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (take) begin
        starve_q <= starve_nxt;
        we_q     <= pick_dm && bus.dm_we;
        be_q     <= pick_dm ? bus.dm_be : '1;
        addr_q   <= pick_dm ? bus.dm_addr : bus.if_addr;
        wdata_q  <= (pick_dm && bus.dm_we) ?
                    bus.dm_wdata : '0;
      end
    end
  end

  assign bus.if_gnt    = arb && rst_n && pick_if;
  assign bus.dm_gnt    = arb && rst_n && pick_dm;
  assign bus.if_rvalid = rsp && (owner_q == OWN_IF);
  assign bus.dm_rvalid = rsp && (owner_q == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ?
                         bus.mem_rdata : '0;
  assign bus.dm_rdata  = (bus.dm_rvalid && !we_q) ?
                         bus.mem_rdata : '0;

  assign bus.mem_req   = (state_q == ARB_ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic quiet;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.dm_be      = '0;
    bus.dm_addr    = '0;
    bus.dm_wdata   = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [138:0] o;
    rst_n = 1'b0;
    quiet();
    bus.if_req     = 1'b1;
    bus.dm_req     = 1'b1;
    bus.mem_rvalid = 1'b1;
    cyc();
    cyc();
    #1;
    o = {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
         bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata,
         bus.mem_req, bus.mem_we, bus.mem_be,
         bus.mem_addr, bus.mem_wdata, bus.busy};
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL reset_outs got=%h exp=0", o);
    end
    cyc();
    quiet();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.mem_req, bus.if_gnt} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_idle got=%b exp=000",
               {bus.busy, bus.mem_req, bus.if_gnt});
    end
  endtask

  task automatic test_fetch;
    cyc();
    quiet();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    vectors++;
    if ({bus.if_gnt, bus.dm_gnt, bus.mem_req, bus.busy}
        !== 4'b1000) begin
      miscompares++;
      $display("FAIL fetch_gnt got=%b exp=1000",
               {bus.if_gnt, bus.dm_gnt, bus.mem_req, bus.busy});
    end
    cyc();
    quiet();
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00500093;
    #1;
    vectors++;
    if ({bus.mem_req, bus.busy, bus.if_rvalid, bus.dm_rvalid,
         bus.if_rdata} !== {4'b1110, 32'h00500093}) begin
      miscompares++;
      $display("FAIL fetch_rsp got=%b/%h exp=1110/00500093",
               {bus.mem_req, bus.busy, bus.if_rvalid, bus.dm_rvalid},
               bus.if_rdata);
    end
    vectors++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata}
        !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_mem got=%h/%b/%h/%h exp=100/0/f/0",
               bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata);
    end
    cyc();
    quiet();
    #1;
    vectors++;
    if ({bus.busy, bus.if_rvalid, bus.mem_req} !== 3'b000) begin
      miscompares++;
      $display("FAIL fetch_done got=%b exp=000",
               {bus.busy, bus.if_rvalid, bus.mem_req});
    end
  endtask

  task automatic test_priority;
    cyc();
    quiet();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h2000;
    bus.dm_be   = 4'hF;
    #1;
    vectors++;
    if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL prio_first got=%b exp=01",
               {bus.if_gnt, bus.dm_gnt});
    end
    cyc();
    bus.dm_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    #1;
    vectors++;
    if ({bus.mem_req, bus.if_gnt, bus.mem_addr}
        !== {2'b10, 32'h2000}) begin
      miscompares++;
      $display("FAIL prio_issue got=%b/%h exp=10/2000",
               {bus.mem_req, bus.if_gnt}, bus.mem_addr);
    end
    cyc();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    #1;
    vectors++;
    if ({bus.dm_rvalid, bus.if_gnt, bus.if_rvalid, bus.dm_rdata}
        !== {3'b100, 32'h1234}) begin
      miscompares++;
      $display("FAIL prio_load got=%b/%h exp=100/1234",
               {bus.dm_rvalid, bus.if_gnt, bus.if_rvalid},
               bus.dm_rdata);
    end
    cyc();
    bus.mem_rvalid = 1'b0;
    #1;
    vectors++;
    if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL prio_second got=%b exp=10",
               {bus.if_gnt, bus.dm_gnt});
    end
    cyc();
    quiet();
    bus.mem_gnt    = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h13;
    #1;
    vectors++;
    if ({bus.if_rvalid, bus.mem_addr, bus.if_rdata}
        !== {1'b1, 32'h300, 32'h13}) begin
      miscompares++;
      $display("FAIL prio_fetch got=%b/%h/%h exp=1/300/13",
               bus.if_rvalid, bus.mem_addr, bus.if_rdata);
    end
    cyc();
    quiet();
  endtask

  task automatic test_starve;
    logic [3:0] e;
    logic [3:0] o;
    int g;
    for (int k = 0; k < 20; k++) begin
      cyc();
      bus.if_req     = 1'b1;
      bus.if_addr    = 32'h40;
      bus.dm_req     = 1'b1;
      bus.dm_addr    = 32'h2000;
      bus.dm_be      = 4'hF;
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom();
      #1;
      g = k / 2;
      if (k % 2 == 0)
        e = (g % 5 == 4) ? 4'b1000 : 4'b0100;
      else
        e = (g % 5 == 4) ? 4'b0010 : 4'b0001;
      o = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL starve_k%0d got=%b exp=%b", k, o, e);
      end
    end
    cyc();
    quiet();
  endtask

  task automatic test_store;
    cyc();
    quiet();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_be    = 4'b0011;
    bus.dm_addr  = 32'h4000;
    bus.dm_wdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if ({bus.dm_gnt, bus.if_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL store_gnt got=%b exp=10",
               {bus.dm_gnt, bus.if_gnt});
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      bus.dm_req   = 1'b0;
      bus.dm_we    = $urandom_range(1);
      bus.dm_be    = $urandom_range(15);
      bus.dm_addr  = $urandom();
      bus.dm_wdata = $urandom();
      bus.mem_gnt  = (k == 4);
      #1;
      vectors++;
      if ({bus.mem_req, bus.dm_rvalid, bus.mem_we, bus.mem_be,
           bus.mem_addr, bus.mem_wdata}
          !== {3'b101, 4'b0011, 32'h4000, 32'hDEADBEEF}) begin
        miscompares++;
        $display("FAIL store_hold_c%0d got=%b/%b/%h/%h", k,
                 {bus.mem_req, bus.dm_rvalid, bus.mem_we},
                 bus.mem_be, bus.mem_addr, bus.mem_wdata);
      end
    end
    cyc();
    quiet();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    #1;
    vectors++;
    if ({bus.dm_rvalid, bus.if_rvalid, bus.mem_req, bus.dm_rdata}
        !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL store_ack got=%b/%h exp=100/0",
               {bus.dm_rvalid, bus.if_rvalid, bus.mem_req},
               bus.dm_rdata);
    end
    cyc();
    quiet();
    #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL store_idle got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [138:0] o;
    cyc();
    quiet();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h500;
    #1;
    vectors++;
    if (bus.if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_gnt got=%b exp=1", bus.if_gnt);
    end
    cyc();
    quiet();
    bus.mem_gnt = 1'b1;
    cyc();
    quiet();
    rst_n          = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555;
    #1;
    vectors++;
    if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b00) begin
      miscompares++;
      $display("FAIL rmid_abort got=%b exp=00",
               {bus.if_rvalid, bus.dm_rvalid});
    end
    cyc();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAAAA;
    #1;
    o = {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
         bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata,
         bus.mem_req, bus.mem_we, bus.mem_be,
         bus.mem_addr, bus.mem_wdata, bus.busy};
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL rmid_late got=%h exp=0", o);
    end
    cyc();
    quiet();
  endtask

  task automatic test_spurious;
    logic [67:0] o;
    for (int k = 0; k < 3; k++) begin
      cyc();
      quiet();
      bus.mem_gnt    = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom();
      #1;
      o = {bus.if_rvalid, bus.dm_rvalid, bus.busy, bus.mem_req,
           bus.if_rdata, bus.dm_rdata};
      vectors++;
      if (o !== '0) begin
        miscompares++;
        $display("FAIL spurious_c%0d got=%h exp=0", k, o);
      end
    end
    cyc();
    quiet();
  endtask

  task automatic test_random(input int n);
    bit          ip, dp, dwe, wif, wdm, mg, mr, rsp;
    logic [31:0] ia, da, dw, rd;
    logic [3:0]  db;
    int          ph, own, loss;
    logic        t_we;
    logic [3:0]  t_be;
    logic [31:0] t_a, t_wd;
    logic [69:0] eo, oo;
    logic [68:0] em, om;
    ip = 0; dp = 0; dwe = 0;
    ia = '0; da = '0; dw = '0; db = '0;
    ph = 0; own = 0; loss = 0;
    t_we = 0; t_be = '0; t_a = '0; t_wd = '0;
    cyc();
    quiet();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      cyc();
      if (!ip && $urandom_range(2) == 0) begin
        ip = 1;
        ia = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dp && $urandom_range(2) == 0) begin
        dp  = 1;
        da  = $urandom();
        dwe = $urandom_range(1);
        db  = $urandom_range(15);
        dw  = $urandom();
      end
      mg = 0;
      mr = 0;
      case (ph)
        0: begin
          mg = $urandom_range(1);
          mr = ($urandom_range(3) == 0);
        end
        1: begin
          mg = ($urandom_range(2) == 0);
          mr = mg && $urandom_range(1);
        end
        default: begin
          mg = $urandom_range(1);
          mr = ($urandom_range(2) == 0);
        end
      endcase
      rd = $urandom();
      bus.if_req     = ip;
      bus.if_addr    = ia;
      bus.dm_req     = dp;
      bus.dm_we      = dwe;
      bus.dm_be      = db;
      bus.dm_addr    = da;
      bus.dm_wdata   = dw;
      bus.mem_gnt    = mg;
      bus.mem_rvalid = mr;
      bus.mem_rdata  = rd;
      #1;
      wdm = (ph == 0) && dp && !(ip && loss == LIM);
      wif = (ph == 0) && ip && !wdm;
      rsp = (ph == 1 && mg && mr) || (ph == 2 && mr);
      eo = {wif, wdm, ph == 1, ph != 0,
            rsp && own == 1, rsp && own == 2,
            (rsp && own == 1) ? rd : 32'h0,
            (rsp && own == 2 && !t_we) ? rd : 32'h0};
      oo = {bus.if_gnt, bus.dm_gnt, bus.mem_req, bus.busy,
            bus.if_rvalid, bus.dm_rvalid,
            bus.if_rdata, bus.dm_rdata};
      vectors++;
      if (oo !== eo) begin
        miscompares++;
        $display("FAIL rand_c%0d got=%h exp=%h", c, oo, eo);
      end
      if (ph == 1) begin
        em = {t_we, t_be, t_a, t_wd};
        om = {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
        vectors++;
        if (om !== em) begin
          miscompares++;
          $display("FAIL rand_mem_c%0d got=%h exp=%h", c, om, em);
        end
      end
      if (ph == 0) begin
        if (wdm) begin
          t_we = dwe;
          t_be = db;
          t_a  = da;
          t_wd = dwe ? dw : 32'h0;
          own  = 2;
          if (ip && loss < LIM) loss++;
          dp = 0;
          ph = 1;
        end else if (wif) begin
          t_we = 0;
          t_be = 4'hF;
          t_a  = ia;
          t_wd = 32'h0;
          own  = 1;
          loss = 0;
          ip   = 0;
          ph   = 1;
        end
      end else if (ph == 1) begin
        if (mg) ph = mr ? 0 : 2;
      end else if (mr) begin
        ph = 0;
      end
    end
    cyc();
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_store();
    test_reset_mid();
    test_spurious();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
